dino_jump_ctrl: RTL and testbench

Jump-physics controller for the dinosaur runner game. It debounces the jump button, starts a jump when the dinosaur is on the ground, and steps a discrete parabolic trajectory on a fixed physics tick. It outputs the current dinosaur height to the renderer and a game-running flag to the ground/scroll logic.

---
 rtl/dino_jump_ctrl.sv | 73 +++++++
 tb/tb_dino_jump_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: debounced jump button launching a tick-stepped parabolic height trajectory
module dino_jump_ctrl #(
  parameter int TICK_DIV      = 1000000,
  parameter int DEBOUNCE_BITS = 4,
  parameter int JUMP_V0       = 10,
  parameter int GRAVITY       = 1
) (
  input  logic       CLK,
  input  logic       clrn,
  input  logic       button_jump,
  output logic [5:0] dinosaur_height,
  output logic       game_status
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic signed [7:0] V0 = 8'(JUMP_V0);
  localparam logic signed [7:0] G  = 8'(GRAVITY);
  typedef enum logic {S_GROUND, S_AIR} state_t;
  state_t                   r_state, w_state_nxt;
  logic [1:0]               r_sync;
  logic [DEBOUNCE_BITS-1:0] r_db;
  logic                     r_lvl, r_lvl_d;
  logic [CW-1:0]            r_cnt;
  logic signed [7:0]        r_vel, w_vel_nxt;
  logic [5:0]               w_h_nxt;
  logic                     w_gs_nxt, w_press, w_tick;
  logic signed [8:0]        w_sum;
  assign w_press = r_lvl & ~r_lvl_d;
  assign w_tick  = r_cnt == CW'(TICK_DIV - 1);
  assign w_sum   = $signed({3'b000, dinosaur_height}) + $signed({r_vel[7], r_vel});
  always_ff @(posedge CLK or negedge clrn)
    if (!clrn) begin
      r_sync          <= '0;
      r_db            <= '0;
      r_lvl           <= 1'b0;
      r_lvl_d         <= 1'b0;
      r_cnt           <= '0;
      r_state         <= S_GROUND;
      r_vel           <= '0;
      dinosaur_height <= '0;
      game_status     <= 1'b0;
    end else begin
      r_sync          <= {r_sync[0], button_jump};
      r_db            <= {r_db[DEBOUNCE_BITS-2:0], r_sync[1]};
      // level rises only on all-ones, falls only on all-zeros, holds on mixed samples
      r_lvl           <= (&r_db) | (r_lvl & (|r_db));
      r_lvl_d         <= r_lvl;
      r_cnt           <= w_tick ? '0 : r_cnt + CW'(1);
      r_state         <= w_state_nxt;
      r_vel           <= w_vel_nxt;
      dinosaur_height <= w_h_nxt;
      game_status     <= w_gs_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_vel_nxt   = r_vel;
    w_h_nxt     = dinosaur_height;
    w_gs_nxt    = game_status;
    if (r_state == S_GROUND && w_press) begin
      w_state_nxt = S_AIR;
      w_vel_nxt   = V0;
      w_gs_nxt    = 1'b1;
    end else if (r_state == S_AIR && w_tick) begin
      if (w_sum <= 9'sd0) begin
        w_state_nxt = S_GROUND;
        w_vel_nxt   = '0;
        w_h_nxt     = '0;
      end else begin
        w_h_nxt   = w_sum > 9'sd63 ? 6'd63 : w_sum[5:0];
        w_vel_nxt = r_vel - G;
      end
    end
  end
endmodule

// File: tb/tb_dino_jump_ctrl.sv
// tb_dino_jump_ctrl: two instances (JUMP_V0 10 and 15) checked every cycle against a behavioural model
module tb_dino_jump_ctrl;
  localparam int TD = 4;
  logic       CLK = 1'b0, clrn = 1'b0, button_jump = 1'b0;
  logic [5:0] h_a, h_b;
  logic       gs_a, gs_b;
  int         errs = 0, checks = 0;
  bit         chk_en = 1'b0;
  int lit10[21] = '{10,19,27,34,40,45,49,52,54,55,55,54,52,49,45,40,34,27,19,10,0};
  int lit15[27] = '{15,29,42,54,63,63,63,63,63,63,63,63,63,63,63,63,62,60,57,53,48,42,35,27,18,8,0};
  int v0s[2] = '{10,15};
  always #5 CLK = ~CLK;
  dino_jump_ctrl #(.TICK_DIV(TD), .DEBOUNCE_BITS(4), .JUMP_V0(10), .GRAVITY(1)) dut_a (
    .CLK(CLK), .clrn(clrn), .button_jump(button_jump), .dinosaur_height(h_a), .game_status(gs_a));
  dino_jump_ctrl #(.TICK_DIV(TD), .DEBOUNCE_BITS(4), .JUMP_V0(15), .GRAVITY(1)) dut_b (
    .CLK(CLK), .clrn(clrn), .button_jump(button_jump), .dinosaur_height(h_b), .game_status(gs_b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: raw samples by age, press when the last four synchronized samples first agree high
  bit samp[7];
  bit m_lvl, m_lvl_d, m_press, tick_now;
  int m_n, m_nx;
  int m_h[2], m_v[2];
  bit m_air[2], m_gs[2];
  initial forever begin
    @(posedge CLK or negedge clrn);
    if (!clrn) begin
      for (int d = 0; d < 7; d++) samp[d] = 1'b0;
      m_lvl = 0; m_lvl_d = 0; m_n = 0; tick_now = 0;
      for (int j = 0; j < 2; j++) begin m_h[j] = 0; m_v[j] = 0; m_air[j] = 0; m_gs[j] = 0; end
    end else begin
      m_press  = m_lvl && !m_lvl_d;
      tick_now = (m_n % TD) == TD - 1;
      for (int j = 0; j < 2; j++)
        if (m_press && !m_air[j]) begin
          m_air[j] = 1; m_v[j] = v0s[j]; m_gs[j] = 1;
        end else if (tick_now && m_air[j]) begin
          m_nx = m_h[j] + m_v[j];
          if (m_nx <= 0) begin m_h[j] = 0; m_v[j] = 0; m_air[j] = 0; end
          else begin m_h[j] = m_nx > 63 ? 63 : m_nx; m_v[j] = m_v[j] - 1; end
        end
      for (int d = 6; d > 0; d--) samp[d] = samp[d-1];
      samp[0] = button_jump;
      m_lvl_d = m_lvl;
      if (samp[3] && samp[4] && samp[5] && samp[6]) m_lvl = 1;
      else if (!(samp[3] || samp[4] || samp[5] || samp[6])) m_lvl = 0;
      m_n++;
    end
  end
  always @(negedge CLK)
    if (chk_en) begin
      chk("h_a", h_a, m_h[0]);
      chk("gs_a", gs_a, m_gs[0]);
      chk("h_b", h_b, m_h[1]);
      chk("gs_b", gs_b, m_gs[1]);
    end
  initial begin
    int cnt;
    repeat (3) @(negedge CLK);
    chk_en = 1;
    clrn = 1;
    repeat (100) @(negedge CLK);
    chk("idle_h", h_a, 0);
    chk("idle_gs", gs_a, 0);
    for (int i = 0; i < 15; i++) begin
      button_jump = ~button_jump;
      repeat (2) @(negedge CLK);
    end
    button_jump = 0;
    repeat (20) @(negedge CLK);
    chk("bounce_h", h_a, 0);
    chk("bounce_gs", gs_a, 0);
    button_jump = 1;
    repeat (7) @(negedge CLK);
    chk("pre_launch_gs", gs_a, 0);
    @(negedge CLK);
    chk("launch_gs", gs_a, 1);
    chk("launch_h", h_a, 0);
    for (int i = 0; i < 27; i++) begin
      cnt = 0;
      do begin @(negedge CLK); cnt++; end while (!tick_now && cnt < 2 * TD);
      chk("tick_seen", tick_now, 1);
      chk("seq_a", h_a, i < 21 ? lit10[i] : 0);
      chk("seq_b", h_b, lit15[i]);
      if (i == 1) button_jump = 0;
      if (i == 9) button_jump = 1;
    end
    repeat (20) @(negedge CLK);
    chk("held_no_relaunch_h", h_a, 0);
    chk("held_gs", gs_a, 1);
    button_jump = 0;
    repeat (10) @(negedge CLK);
    button_jump = 1;
    repeat (8) @(negedge CLK);
    cnt = 0;
    do begin @(negedge CLK); cnt++; end while (!tick_now && cnt < 2 * TD);
    chk("relaunch_a", h_a, 10);
    chk("relaunch_b", h_b, 15);
    button_jump = 0;
    cnt = 0;
    do begin @(negedge CLK); cnt++; end while (h_a != 6'd40 && cnt < 100);
    chk("reach40", h_a, 40);
    #2 clrn = 0;
    #1;
    chk("async_h_a", h_a, 0);
    chk("async_gs_a", gs_a, 0);
    chk("async_h_b", h_b, 0);
    @(negedge CLK);
    clrn = 1;
    repeat (40) @(negedge CLK);
    chk("post_reset_h", h_a, 0);
    chk("post_reset_gs", gs_a, 0);
    repeat (400) begin
      button_jump = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 12)) @(negedge CLK);
      if ($urandom_range(0, 59) == 0) begin
        #2 clrn = 0;
        @(negedge CLK);
        clrn = 1;
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
